// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enabled VGA raster counters with registered sync, blank, de and start strobes
module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW) || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("vga_timing_gen: totals exceed counter width or a phase length is zero");
  end
  logic [CW-1:0] r_hc, r_vc;
  logic w_hend, w_vend, w_hb, w_vb;
  always_comb begin
    w_hend = r_hc == H_LAST;
    w_vend = r_vc == V_LAST;
    w_hb   = r_hc >= H_ACT;
    w_vb   = r_vc >= V_ACT;
  end
  // outputs decode the pre-increment position, so they trail the counters by one ce-cycle
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_hc        <= '0;
      r_vc        <= '0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= ce && r_hc == '0;
      frame_start <= ce && r_hc == '0 && r_vc == '0;
      if (ce) begin
        r_hc   <= w_hend ? '0 : r_hc + 1'b1;
        r_vc   <= w_hend ? (w_vend ? '0 : r_vc + 1'b1) : r_vc;
        hcount <= r_hc;
        vcount <= r_vc;
        hsync  <= (r_hc >= HS_BEG && r_hc <= HS_END) ? HS_POL : ~HS_POL;
        vsync  <= (r_vc >= VS_BEG && r_vc <= VS_END) ? VS_POL : ~VS_POL;
        hblnk  <= w_hb;
        vblnk  <= w_vb;
        de     <= !w_hb && !w_vb;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random ce/rst stimulus on a default and a small low-polarity instance, checked against a raster-position model
module tb_vga_timing_gen;
  logic pclk = 1'b0, rst = 1'b1, ce = 1'b0;
  logic [10:0] d_hc, d_vc;
  logic [3:0]  s_hc, s_vc;
  logic d_hs, d_vs, d_hb, d_vb, d_de, d_ls, d_fs;
  logic s_hs, s_vs, s_hb, s_vb, s_de, s_ls, s_fs;
  int n_cmp = 0, n_bad = 0;
  longint n = 0;
  bit lce = 1'b0;
  always #5 pclk = ~pclk;
  vga_timing_gen u_dflt (
    .pclk(pclk), .rst(rst), .ce(ce), .hcount(d_hc), .vcount(d_vc), .hsync(d_hs), .vsync(d_vs),
    .hblnk(d_hb), .vblnk(d_vb), .de(d_de), .line_start(d_ls), .frame_start(d_fs)
  );
  vga_timing_gen #(
    .CW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_small (
    .pclk(pclk), .rst(rst), .ce(ce), .hcount(s_hc), .vcount(s_vc), .hsync(s_hs), .vsync(s_vs),
    .hblnk(s_hb), .vblnk(s_vb), .de(s_de), .line_start(s_ls), .frame_start(s_fs)
  );
  // n counts ce edges since reset; the outputs show raster position n-1
  function automatic logic [38:0] model(longint cnt, bit lc, int ha, int hf, int hw, int hb,
                                        int va, int vf, int vw, int vb, bit hp, bit vp);
    longint p, h, v;
    int ht, vt;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    if (cnt == 0) return {16'd0, 16'd0, ~hp, ~vp, 5'd0};
    p = cnt - 1;
    h = p % ht;
    v = (p / ht) % vt;
    return {16'(h), 16'(v),
            (h >= ha + hf && h < ha + hf + hw) ? hp : ~hp,
            (v >= va + vf && v < va + vf + vw) ? vp : ~vp,
            h >= ha, v >= va, h < ha && v < va, lc && h == 0, lc && h == 0 && v == 0};
  endfunction
  task automatic check(string tag, logic [38:0] got, logic [38:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s n=%0d got=%h want=%h (h,v,hs,vs,hb,vb,de,ls,fs)", tag, n, got, exp);
    end
  endtask
  task automatic step(bit r, bit c);
    rst = r;
    ce  = c;
    @(posedge pclk);
    if (r) begin
      n   = 0;
      lce = 1'b0;
    end else begin
      if (c) n++;
      lce = c;
    end
    #1;
    check("dflt", {16'(d_hc), 16'(d_vc), d_hs, d_vs, d_hb, d_vb, d_de, d_ls, d_fs},
          model(n, lce, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1));
    check("small", {16'(s_hc), 16'(s_vc), s_hs, s_vs, s_hb, s_vb, s_de, s_ls, s_fs},
          model(n, lce, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0));
  endtask
  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 2500; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 4400; i++) step(1'b0, 1'(i % 2 == 0));
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 499) == 0, 1'($urandom));
    step(1'b1, 1'b0);
    for (int i = 0; i < 2000 && (n == 0 || (n - 1) % 1056 != 500); i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 1200; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 2000; i++) step(1'b0, $urandom_range(0, 3) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
